rx_udp: RTL and testbench
=========================

# rx_udp

Receive-side UDP parser sitting directly downstream of the IPv4 receive stage, in the `RX_CLK` domain. It consumes the per-byte UDP datagram stream (`rx_data_udp` / `rx_data`) and the captured source IP from the IPv4 stage, then parses the 8-byte UDP header. It filters on destination port and presents the payload to the application as a framed byte stream with start, end and error markers. The UDP checksum is captured but not verified.

## Interface
- `OCT`, 8, bits per byte.
- `UDP_HDR_LEN`, 8, UDP header length in bytes.
- `RX_CLK` in 1: receive clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `udp_port` in 16: local listening port; 0 accepts every port.
- `rx_data_udp` in 1: byte valid from the IPv4 stage.
  - A datagram is one contiguous run of valid.
  - Runs are separated by at least one low cycle.
- `rx_data` in 8: datagram byte, network order.
- `rx_src_ip` in 32: source IP from the IPv4 stage; stable while `rx_data_udp` is high.
- `rx_src_port` out 16: captured source port.
- `rx_dst_port` out 16: captured destination port.
- `rx_udp_len` out 16: captured UDP length field.
- `rx_udp_csum` out 16: captured checksum field.
- `rx_app_src_ip` out 32: `rx_src_ip`, latched on the first header byte.
- `rx_app_valid` out 1: payload byte valid.
- `rx_app_data` out 8: payload byte.
- `rx_app_sop` out 1: high with the first payload byte.
- `rx_app_eop` out 1: high with the last payload byte, as given by the length field.
- `rx_app_err` out 1: one-cycle pulse marking a malformed or truncated accepted datagram.

## Operation
- States:
  - S_SRC (2 bytes)
  - S_DST (2 bytes)
  - S_LEN (2 bytes)
  - S_CSUM (2 bytes)
  - S_PAY
  - S_DRAIN
- A 16-bit byte counter `cnt` tracks position within each state.
- Header fields shift in MSB first.
- Every transition below applies only on cycles with `rx_data_udp` = 1, except the valid-fall rule.
- Header sequencing:
  - S_SRC → S_DST → S_LEN → S_CSUM, each after 2 bytes.
  - `rx_app_src_ip` latches on the first S_SRC byte.
- After the second S_CSUM byte, with `len` = captured length, the next state is chosen in this order:
  - `len` < 8 → S_DRAIN, with `err_pend` set.
  - Port mismatch (`udp_port` ≠ 0 and `rx_dst_port` ≠ `udp_port`) → S_DRAIN, no error.
  - `len` == 8 → S_DRAIN; zero payload, no app beats, no error.
  - Otherwise → S_PAY with `cnt` = `len` − 8.
- S_PAY:
  - Each byte drives `rx_app_valid` with `rx_app_data` = byte.
  - `sop` is high on the first byte.
  - `cnt` decrements per byte.
  - When `cnt` == 1, the byte carries `eop` and the state goes to S_DRAIN.
  - `sop` and `eop` may coincide (1-byte payload).
- S_DRAIN: bytes are ignored. Trailing Ethernet padding beyond the UDP length never reaches the application.
- Valid-fall rule: on the first cycle with `rx_data_udp` = 0, from any state other than S_SRC with `cnt` = 0:
  - The state returns to S_SRC and `cnt` clears.
  - `rx_app_err` pulses if the datagram was accepted (port match, `len` ≥ 8) and fell in S_PAY before `eop`.
  - `rx_app_err` also pulses if `err_pend` is set.
  - A truncated header (fall before the second S_CSUM byte) pulses `rx_app_err` only when the port is already known to match. Truncation inside S_SRC/S_DST gives no error.
- Captured header outputs hold until the next datagram overwrites them.
- Arithmetic: `len` − 8 is a 16-bit unsigned subtraction, evaluated only when `len` ≥ 8. Lengths up to 65535 are legal.

## Timing
- All outputs are registered.
- Input byte at edge t appears on `rx_app_*` after edge t+1; latency is 1 cycle.
- `rx_app_valid` is never high for two datagrams without at least one low cycle between them.
- `rx_app_err` is asserted for exactly one cycle, the cycle after `rx_data_udp` falls. It never coincides with `rx_app_valid`.
- There is no backpressure; the application must accept a byte every valid cycle.
- Reset (`rst_n` low, asynchronous):
  - State returns to S_SRC; `cnt` and `err_pend` clear.
  - All outputs go to 0.
- Reset mid-datagram abandons it with no `eop` and no `err`. Parsing resumes on the next rising run of `rx_data_udp` after release.

## Structure
- Shared package holds:
  - state encodings
  - `UDP_HDR_LEN`
  - `PROTO_UDP` (8'h11)
  - a 16-bit port type shared with the TX UDP stage
- Single module; no sub-module is warranted. The byte counter and header shift registers stay inline.

## Test plan
- Port 5000, datagram src 1234 / dst 5000, len 12, payload DE AD BE EF → four app beats; `sop` on DE, `eop` on EF; `rx_src_port` = 1234, `rx_udp_len` = 12, no `err`.
- Same datagram with dst 5001 → no app beats, no `err`; `rx_dst_port` = 5001.
- `udp_port` = 0, len 9, payload 55, then 10 padding bytes → single beat with `sop` = `eop` = 1; padding dropped.
- len 20, valid drops after 5 payload bytes → 5 beats, no `eop`, `rx_app_err` pulse the cycle after the fall.
- len 6 with matching port → no beats, one `err` pulse at valid fall.
- `rst_n` pulsed low during payload, then a clean datagram → all outputs 0 during reset; the following datagram is parsed correctly.

Source files
------------

// File: rtl/rx_udp_pkg.sv
// rx_udp_pkg: constants and types shared by the UDP receive and transmit stages.
package rx_udp_pkg;
  localparam int OCT = 8;
  localparam int UDP_HDR_LEN = 8;
  localparam logic [7:0] PROTO_UDP = 8'h11;
  typedef logic [15:0] udp_port_t;
  typedef enum logic [2:0] {S_SRC, S_DST, S_LEN, S_CSUM, S_PAY, S_DRAIN} state_t;
endpackage

// File: rtl/rx_udp_if.sv
// rx_udp_if: datagram byte stream from the IPv4 stage plus parsed header and payload stream.
interface rx_udp_if;
  import rx_udp_pkg::*;
  logic rx_data_udp;
  logic [OCT-1:0] rx_data;
  logic [31:0] rx_src_ip;
  udp_port_t rx_src_port;
  udp_port_t rx_dst_port;
  logic [15:0] rx_udp_len;
  logic [15:0] rx_udp_csum;
  logic [31:0] rx_app_src_ip;
  logic rx_app_valid;
  logic [OCT-1:0] rx_app_data;
  logic rx_app_sop;
  logic rx_app_eop;
  logic rx_app_err;
  modport master (
    output rx_data_udp, rx_data, rx_src_ip,
    input rx_src_port, rx_dst_port, rx_udp_len, rx_udp_csum, rx_app_src_ip,
    input rx_app_valid, rx_app_data, rx_app_sop, rx_app_eop, rx_app_err
  );
  modport slave (
    input rx_data_udp, rx_data, rx_src_ip,
    output rx_src_port, rx_dst_port, rx_udp_len, rx_udp_csum, rx_app_src_ip,
    output rx_app_valid, rx_app_data, rx_app_sop, rx_app_eop, rx_app_err
  );
endinterface

// File: rtl/rx_udp.sv
// rx_udp: parses the UDP header, filters on destination port and frames the payload
// for the application with sop/eop/err markers; one cycle of latency, no backpressure.
module rx_udp
  import rx_udp_pkg::*;
(
  input  logic      RX_CLK,
  input  logic      rst_n,
  input  udp_port_t udp_port,
  rx_udp_if.slave   bus
);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_pend_q, err_pend_d;
  logic first_q, first_d;
  udp_port_t src_q, src_d, dst_q, dst_d;
  logic [15:0] len_q, len_d, csum_q, csum_d;
  logic [31:0] ip_q, ip_d;
  logic val_q, val_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [OCT-1:0] dat_q, dat_d;
  logic port_ok, hdr_done, idle;
  assign port_ok  = (udp_port == '0) || (dst_q == udp_port);
  assign hdr_done = cnt_q == 16'd1;
  assign idle     = (state_q == S_SRC) && (cnt_q == '0);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    first_d    = first_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    csum_d     = csum_q;
    ip_d       = ip_q;
    dat_d      = dat_q;
    val_d      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    if (bus.rx_data_udp) begin
      case (state_q)
        S_SRC, S_DST, S_LEN, S_CSUM: begin
          cnt_d  = hdr_done ? 16'd0 : 16'd1;
          src_d  = (state_q == S_SRC)  ? {src_q[7:0], bus.rx_data}  : src_q;
          dst_d  = (state_q == S_DST)  ? {dst_q[7:0], bus.rx_data}  : dst_q;
          len_d  = (state_q == S_LEN)  ? {len_q[7:0], bus.rx_data}  : len_q;
          csum_d = (state_q == S_CSUM) ? {csum_q[7:0], bus.rx_data} : csum_q;
          ip_d   = idle ? bus.rx_src_ip : ip_q;
          if (hdr_done) begin
            state_d = (state_q == S_SRC) ? S_DST :
                      (state_q == S_DST) ? S_LEN :
                      (state_q == S_LEN) ? S_CSUM : S_DRAIN;
            // header complete: short length is an error even when the port does not match
            if (state_q == S_CSUM) begin
              err_pend_d = len_q < 16'(UDP_HDR_LEN);
              if (len_q > 16'(UDP_HDR_LEN) && port_ok) begin
                state_d = S_PAY;
                cnt_d   = len_q - 16'(UDP_HDR_LEN);
                first_d = 1'b1;
              end
            end
          end
        end
        S_PAY: begin
          val_d   = 1'b1;
          dat_d   = bus.rx_data;
          sop_d   = first_q;
          eop_d   = hdr_done;
          first_d = 1'b0;
          cnt_d   = cnt_q - 16'd1;
          state_d = hdr_done ? S_DRAIN : S_PAY;
        end
        default: ;
      endcase
    end else if (!idle) begin
      state_d    = S_SRC;
      cnt_d      = '0;
      err_pend_d = 1'b0;
      first_d    = 1'b0;
      err_d      = err_pend_q || (state_q == S_PAY) ||
                   (((state_q == S_LEN) || (state_q == S_CSUM)) && port_ok);
    end
  end
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SRC;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      first_q    <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      ip_q       <= '0;
      dat_q      <= '0;
      val_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      first_q    <= first_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      ip_q       <= ip_d;
      dat_q      <= dat_d;
      val_q      <= val_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
    end
  end
  assign bus.rx_src_port   = src_q;
  assign bus.rx_dst_port   = dst_q;
  assign bus.rx_udp_len    = len_q;
  assign bus.rx_udp_csum   = csum_q;
  assign bus.rx_app_src_ip = ip_q;
  assign bus.rx_app_valid  = val_q;
  assign bus.rx_app_data   = dat_q;
  assign bus.rx_app_sop    = sop_q;
  assign bus.rx_app_eop    = eop_q;
  assign bus.rx_app_err    = err_q;
endmodule

// File: tb/tb_rx_udp.sv
// tb_rx_udp: directed datagrams checked every cycle against a datagram-level expectation model.
module tb_rx_udp;
  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       r;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] udp_port;
  rx_udp_if bus();

  rx_udp dut (.RX_CLK(clk), .rst_n(rst_n), .udp_port(udp_port), .bus(bus));

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int n_beats = 0;
  int n_errs = 0;
  beat_t exp_next = '0;
  beat_t exp_cur = '0;
  beat_t act_b, exp_b;
  logic [7:0] pkt[$];

  always @(posedge clk) exp_cur <= exp_next;

  always @(negedge clk) begin
    act_b = '{bus.rx_app_valid, bus.rx_app_data, bus.rx_app_sop, bus.rx_app_eop, bus.rx_app_err};
    exp_b = rst_n ? exp_cur : '0;
    if (!exp_b.v) begin
      act_b.d = '0;
      exp_b.d = '0;
    end
    if (bus.rx_app_valid) n_beats++;
    if (bus.rx_app_err) n_errs++;
    compared++;
    if (act_b !== exp_b) begin
      mismatched++;
      $display("FAIL app_beat t=%0t got v%b d%h s%b e%b r%b required v%b d%h s%b e%b r%b",
               $time, act_b.v, act_b.d, act_b.s, act_b.e, act_b.r,
               exp_b.v, exp_b.d, exp_b.s, exp_b.e, exp_b.r);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input logic [15:0] c);
    pkt.delete();
    pkt.push_back(s[15:8]); pkt.push_back(s[7:0]);
    pkt.push_back(d[15:8]); pkt.push_back(d[7:0]);
    pkt.push_back(l[15:8]); pkt.push_back(l[7:0]);
    pkt.push_back(c[15:8]); pkt.push_back(c[7:0]);
  endtask

  // Sends the first n bytes of pkt; abort replaces the valid fall by a reset pulse.
  task automatic send(input int n, input bit abort);
    int l;
    bit match, acc, v;
    l = int'({pkt[4], pkt[5]});
    match = (udp_port == 16'd0) || ({pkt[2], pkt[3]} == udp_port);
    acc = (l >= 8) && match;
    for (int i = 0; i < n; i++) begin
      bus.rx_data_udp = 1'b1;
      bus.rx_data = pkt[i];
      v = acc && (i >= 8) && (i < l);
      exp_next = '{v, pkt[i], v && (i == 8), v && (i == l - 1), 1'b0};
      @(posedge clk); #1;
    end
    bus.rx_data_udp = 1'b0;
    bus.rx_data = 8'h00;
    if (abort) begin
      rst_n = 1'b0;
      exp_next = '0;
      @(posedge clk); #1;
      check("rst_src_port", {16'd0, bus.rx_src_port}, 32'd0);
      check("rst_udp_len", {16'd0, bus.rx_udp_len}, 32'd0);
      check("rst_src_ip", bus.rx_app_src_ip, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      exp_next = '{1'b0, 8'h00, 1'b0, 1'b0,
                   (n >= 8) ? ((l < 8) || (acc && (l > 8) && (n < l))) : ((n >= 4) && match)};
    end
    @(posedge clk); #1;
    exp_next = '0;
    @(posedge clk); #1;
  endtask

  int b0, e0;

  initial begin
    rst_n = 1'b0;
    udp_port = 16'd5000;
    bus.rx_data_udp = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_src_ip = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, bus.rx_app_valid}, 32'd0);
    check("reset_err", {31'd0, bus.rx_app_err}, 32'd0);
    check("reset_dst_port", {16'd0, bus.rx_dst_port}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: accepted 4-byte payload
    bus.rx_src_ip = 32'hC0A8_0001;
    hdr(16'd1234, 16'd5000, 16'd12, 16'hABCD);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    b0 = n_beats; e0 = n_errs;
    send(12, 1'b0);
    check("t1_beats", n_beats - b0, 32'd4);
    check("t1_errs", n_errs - e0, 32'd0);
    check("t1_src_port", {16'd0, bus.rx_src_port}, 32'd1234);
    check("t1_udp_len", {16'd0, bus.rx_udp_len}, 32'd12);
    check("t1_csum", {16'd0, bus.rx_udp_csum}, 32'hABCD);
    check("t1_src_ip", bus.rx_app_src_ip, 32'hC0A8_0001);

    // 2: port mismatch
    bus.rx_src_ip = 32'h0A00_0002;
    pkt[3] = 8'h89;
    b0 = n_beats; e0 = n_errs;
    send(12, 1'b0);
    check("t2_beats", n_beats - b0, 32'd0);
    check("t2_errs", n_errs - e0, 32'd0);
    check("t2_dst_port", {16'd0, bus.rx_dst_port}, 32'd5001);
    check("t2_src_ip", bus.rx_app_src_ip, 32'h0A00_0002);

    // 3: wildcard port, 1-byte payload followed by padding
    udp_port = 16'd0;
    hdr(16'd7, 16'd7777, 16'd9, 16'h0000);
    pkt.push_back(8'h55);
    repeat (10) pkt.push_back(8'hA5);
    b0 = n_beats; e0 = n_errs;
    send(19, 1'b0);
    check("t3_beats", n_beats - b0, 32'd1);
    check("t3_errs", n_errs - e0, 32'd0);

    // 4: truncated payload
    udp_port = 16'd5000;
    hdr(16'd1, 16'd5000, 16'd20, 16'h1111);
    for (int i = 0; i < 12; i++) pkt.push_back(8'(8'h10 + i));
    b0 = n_beats; e0 = n_errs;
    send(13, 1'b0);
    check("t4_beats", n_beats - b0, 32'd5);
    check("t4_errs", n_errs - e0, 32'd1);

    // 5: length below header size
    hdr(16'd2, 16'd5000, 16'd6, 16'h2222);
    repeat (4) pkt.push_back(8'h00);
    b0 = n_beats; e0 = n_errs;
    send(12, 1'b0);
    check("t5_beats", n_beats - b0, 32'd0);
    check("t5_errs", n_errs - e0, 32'd1);
    check("t5_udp_len", {16'd0, bus.rx_udp_len}, 32'd6);

    // header truncations and zero-length payload
    hdr(16'd3, 16'd5000, 16'd12, 16'h3333);
    repeat (4) pkt.push_back(8'h77);
    e0 = n_errs;
    send(3, 1'b0);
    check("trunc_dst_errs", n_errs - e0, 32'd0);
    e0 = n_errs;
    send(7, 1'b0);
    check("trunc_csum_errs", n_errs - e0, 32'd1);
    hdr(16'd4, 16'd5000, 16'd8, 16'h4444);
    pkt.push_back(8'h99);
    b0 = n_beats; e0 = n_errs;
    send(9, 1'b0);
    check("len8_beats", n_beats - b0, 32'd0);
    check("len8_errs", n_errs - e0, 32'd0);

    // 6: reset during payload, then a clean datagram
    hdr(16'd9, 16'd5000, 16'd12, 16'h5555);
    pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03); pkt.push_back(8'h04);
    e0 = n_errs;
    send(10, 1'b1);
    check("t6_abort_errs", n_errs - e0, 32'd0);
    bus.rx_src_ip = 32'h0102_0304;
    hdr(16'd4321, 16'd5000, 16'd12, 16'h6666);
    pkt.push_back(8'hCA); pkt.push_back(8'hFE); pkt.push_back(8'hBA); pkt.push_back(8'hBE);
    b0 = n_beats; e0 = n_errs;
    send(12, 1'b0);
    check("t6_beats", n_beats - b0, 32'd4);
    check("t6_errs", n_errs - e0, 32'd0);
    check("t6_src_port", {16'd0, bus.rx_src_port}, 32'd4321);
    check("t6_src_ip", bus.rx_app_src_ip, 32'h0102_0304);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
